// File: rtl/rs_multi_fu_pkg.sv
// Shared types and default widths for the multi-FU reservation station.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

package rs_pkg;
   localparam int RS_DEPTH   = 8;
   localparam int RS_DATA_W  = `REG_VAL_WIDTH;
   localparam int RS_TAG_W   = `PHYSICAL_REG_NUM_WIDTH;
   localparam int RS_NUM_CDB = 2;

   typedef enum logic {
      FU_ADD = 1'b0,
      FU_MUL = 1'b1
   } fu_type_t;

   // Entry layout at the default operand/tag widths
   typedef struct packed {
      logic                 valid;
      fu_type_t             fu;
      logic                 s1_rdy;
      logic [RS_TAG_W-1:0]  s1_tag;
      logic [RS_DATA_W-1:0] s1_val;
      logic                 s2_rdy;
      logic [RS_TAG_W-1:0]  s2_tag;
      logic [RS_DATA_W-1:0] s2_val;
      logic [RS_TAG_W-1:0]  dst;
   } rs_entry_t;
endpackage

// File: rtl/rs_multi_fu_if.sv
// Dispatch, wakeup and issue bus of the reservation station.
interface rs_multi_fu_if #(
   parameter int DEPTH   = rs_pkg::RS_DEPTH,
   parameter int DATA_W  = rs_pkg::RS_DATA_W,
   parameter int TAG_W   = rs_pkg::RS_TAG_W,
   parameter int NUM_CDB = rs_pkg::RS_NUM_CDB
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                      flush;
   logic                      disp_valid;
   logic                      disp_ready;
   logic                      disp_fu;
   logic                      disp_src1_rdy;
   logic [TAG_W-1:0]          disp_src1_tag;
   logic [DATA_W-1:0]         disp_src1_val;
   logic                      disp_src2_rdy;
   logic [TAG_W-1:0]          disp_src2_tag;
   logic [DATA_W-1:0]         disp_src2_val;
   logic                      disp_use_imm;
   logic [DATA_W-1:0]         disp_imm;
   logic [TAG_W-1:0]          disp_dst;
   logic [NUM_CDB-1:0]        cdb_valid;
   logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
   logic [NUM_CDB*DATA_W-1:0] cdb_val;
   logic                      add_valid;
   logic                      add_ready;
   logic [DATA_W-1:0]         add_op1;
   logic [DATA_W-1:0]         add_op2;
   logic [TAG_W-1:0]          add_dst;
   logic                      mul_valid;
   logic                      mul_ready;
   logic [DATA_W-1:0]         mul_op1;
   logic [DATA_W-1:0]         mul_op2;
   logic [TAG_W-1:0]          mul_dst;
   logic [CNT_W-1:0]          count;

   modport master (
      output flush, disp_valid, disp_fu, disp_src1_rdy, disp_src1_tag, disp_src1_val,
             disp_src2_rdy, disp_src2_tag, disp_src2_val, disp_use_imm, disp_imm, disp_dst,
             cdb_valid, cdb_tag, cdb_val, add_ready, mul_ready,
      input  disp_ready, add_valid, add_op1, add_op2, add_dst,
             mul_valid, mul_op1, mul_op2, mul_dst, count
   );

   modport slave (
      input  flush, disp_valid, disp_fu, disp_src1_rdy, disp_src1_tag, disp_src1_val,
             disp_src2_rdy, disp_src2_tag, disp_src2_val, disp_use_imm, disp_imm, disp_dst,
             cdb_valid, cdb_tag, cdb_val, add_ready, mul_ready,
      output disp_ready, add_valid, add_op1, add_op2, add_dst,
             mul_valid, mul_op1, mul_op2, mul_dst, count
   );
endinterface

// File: rtl/rs_multi_fu_prio_sel.sv
// Lowest-index-set picker: one-hot grant, binary index and any-set flag.
module rs_prio_sel #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);
   // Scan upward; the first set bit claims the grant
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i] && !any) begin
            onehot[i] = 1'b1;
            idx       = IW'(i);
            any       = 1'b1;
         end
      end
   end
endmodule

// File: rtl/rs_multi_fu.sv
// Reservation station: dispatch with CDB bypass, tag wakeup, lowest-index
// issue to independent ADD and MUL channels, and full flush.
module rs_multi_fu
   import rs_pkg::*;
#(
   parameter int DEPTH   = RS_DEPTH,
   parameter int DATA_W  = RS_DATA_W,
   parameter int TAG_W   = RS_TAG_W,
   parameter int NUM_CDB = RS_NUM_CDB
) (
   input logic          clk,
   input logic          reset,
   rs_multi_fu_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   typedef struct packed {
      logic              valid;
      fu_type_t          fu;
      logic              s1_rdy;
      logic [TAG_W-1:0]  s1_tag;
      logic [DATA_W-1:0] s1_val;
      logic              s2_rdy;
      logic [TAG_W-1:0]  s2_tag;
      logic [DATA_W-1:0] s2_val;
      logic [TAG_W-1:0]  dst;
   } entry_t;

   entry_t ent_q [DEPTH];
   entry_t ent_d [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [DEPTH-1:0] free_req, add_req, mul_req;
   logic [DEPTH-1:0] free_oh, add_oh, mul_oh;
   logic [IDX_W-1:0] free_idx, add_idx, mul_idx;
   logic             free_any, add_any, mul_any;
   logic             disp_rdy, disp_fire, add_fire, mul_fire;
   logic [IDX_W-1:0] sel_unused;

   // Returns {ready, value}; lowest matching CDB port wins
   function automatic logic [DATA_W:0] snoop(
      input logic                      rdy,
      input logic [TAG_W-1:0]          tag,
      input logic [DATA_W-1:0]         val,
      input logic [NUM_CDB-1:0]        cv,
      input logic [NUM_CDB*TAG_W-1:0]  ct,
      input logic [NUM_CDB*DATA_W-1:0] cval
   );
      logic              hit;
      logic [DATA_W-1:0] v;
      hit = rdy;
      v   = val;
      for (int p = 0; p < NUM_CDB; p++) begin
         if (!hit && cv[p] && (ct[p*TAG_W +: TAG_W] == tag)) begin
            hit = 1'b1;
            v   = cval[p*DATA_W +: DATA_W];
         end
      end
      return {hit, v};
   endfunction

   // Per-entry request vectors from registered state
   always_comb begin
      free_req = '0;
      add_req  = '0;
      mul_req  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         free_req[i] = !ent_q[i].valid;
         add_req[i]  = ent_q[i].valid && (ent_q[i].fu == FU_ADD) && ent_q[i].s1_rdy && ent_q[i].s2_rdy;
         mul_req[i]  = ent_q[i].valid && (ent_q[i].fu == FU_MUL) && ent_q[i].s1_rdy && ent_q[i].s2_rdy;
      end
   end

   rs_prio_sel #(.N(DEPTH)) u_free_sel (.req(free_req), .onehot(free_oh), .idx(free_idx), .any(free_any));
   rs_prio_sel #(.N(DEPTH)) u_add_sel  (.req(add_req),  .onehot(add_oh),  .idx(add_idx),  .any(add_any));
   rs_prio_sel #(.N(DEPTH)) u_mul_sel  (.req(mul_req),  .onehot(mul_oh),  .idx(mul_idx),  .any(mul_any));

   assign sel_unused = free_idx;

   // Count-only admission so a same-cycle issue never frees room for dispatch
   assign disp_rdy  = (cnt_q < CNT_W'(DEPTH));
   assign disp_fire = bus.disp_valid && disp_rdy && free_any;
   assign add_fire  = add_any && bus.add_ready;
   assign mul_fire  = mul_any && bus.mul_ready;

   assign bus.disp_ready = disp_rdy;
   assign bus.count      = cnt_q;
   assign bus.add_valid  = add_any;
   assign bus.add_op1    = add_any ? ent_q[add_idx].s1_val : '0;
   assign bus.add_op2    = add_any ? ent_q[add_idx].s2_val : '0;
   assign bus.add_dst    = add_any ? ent_q[add_idx].dst    : '0;
   assign bus.mul_valid  = mul_any;
   assign bus.mul_op1    = mul_any ? ent_q[mul_idx].s1_val : '0;
   assign bus.mul_op2    = mul_any ? ent_q[mul_idx].s2_val : '0;
   assign bus.mul_dst    = mul_any ? ent_q[mul_idx].dst    : '0;

   // Next entry state: wakeup, issue free, dispatch write, then flush override
   always_comb begin
      logic [DATA_W:0] w1;
      logic [DATA_W:0] w2;
      w1 = '0;
      w2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         if (ent_q[i].valid) begin
            w1 = snoop(ent_q[i].s1_rdy, ent_q[i].s1_tag, ent_q[i].s1_val,
                       bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
            w2 = snoop(ent_q[i].s2_rdy, ent_q[i].s2_tag, ent_q[i].s2_val,
                       bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
            ent_d[i].s1_rdy = w1[DATA_W];
            ent_d[i].s1_val = w1[DATA_W-1:0];
            ent_d[i].s2_rdy = w2[DATA_W];
            ent_d[i].s2_val = w2[DATA_W-1:0];
         end
         if ((add_fire && add_oh[i]) || (mul_fire && mul_oh[i])) begin
            ent_d[i].valid = 1'b0;
         end
         if (disp_fire && free_oh[i]) begin
            w1 = snoop(bus.disp_src1_rdy, bus.disp_src1_tag, bus.disp_src1_val,
                       bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
            w2 = bus.disp_use_imm ? {1'b1, bus.disp_imm}
                                  : snoop(bus.disp_src2_rdy, bus.disp_src2_tag, bus.disp_src2_val,
                                          bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
            ent_d[i].valid  = 1'b1;
            ent_d[i].fu     = fu_type_t'(bus.disp_fu);
            ent_d[i].s1_rdy = w1[DATA_W];
            ent_d[i].s1_tag = bus.disp_src1_tag;
            ent_d[i].s1_val = w1[DATA_W-1:0];
            ent_d[i].s2_rdy = w2[DATA_W];
            ent_d[i].s2_tag = bus.disp_src2_tag;
            ent_d[i].s2_val = w2[DATA_W-1:0];
            ent_d[i].dst    = bus.disp_dst;
         end
         if (bus.flush) begin
            ent_d[i].valid = 1'b0;
         end
      end
      cnt_d = cnt_q + CNT_W'(disp_fire) - CNT_W'(add_fire) - CNT_W'(mul_fire);
      if (bus.flush) begin
         cnt_d = '0;
      end
   end

   // Entry and occupancy registers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
         cnt_q <= cnt_d;
      end
   end
endmodule
